// File: rtl/i2s_adc_receiver_pkg.sv
// Shared constants and state encodings for the slave-mode I2S capture path.
package i2s_adc_receiver_pkg;

  localparam int I2S_DATA_W   = 32;
  localparam int I2S_MAX_SLOT = 64;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge.sv
// Brings the asynchronous I2S pins into the clk domain and strobes once per BCLK rise.
module i2s_adc_receiver_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic ws_s,
  output logic sd_s,
  output logic bit_stb
);

  logic sck_q1, sck_q2, sck_q3;
  logic ws_q1, ws_q2;
  logic sd_q1, sd_q2;

  // bit_stb is registered so it lands 3 clk after the pin edge; ws/sd are held
  // stable by the transmitter long enough for ws_q2/sd_q2 to still be valid then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q1  <= 1'b0;
      sck_q2  <= 1'b0;
      sck_q3  <= 1'b0;
      ws_q1   <= 1'b0;
      ws_q2   <= 1'b0;
      sd_q1   <= 1'b0;
      sd_q2   <= 1'b0;
      bit_stb <= 1'b0;
    end else begin
      sck_q1  <= sck;
      sck_q2  <= sck_q1;
      sck_q3  <= sck_q2;
      ws_q1   <= ws;
      ws_q2   <= ws_q1;
      sd_q1   <= sd;
      sd_q2   <= sd_q1;
      bit_stb <= sck_q2 & ~sck_q3;
    end
  end

  assign ws_s = ws_q2;
  assign sd_s = sd_q2;

endmodule

// File: rtl/i2s_adc_receiver.sv
// Slave-mode Philips I2S receiver: deserializes left/right words and hands pairs
// downstream over valid/ready.
module i2s_adc_receiver
  import i2s_adc_receiver_pkg::*;
#(
  parameter int DATA_W   = I2S_DATA_W,
  parameter int MAX_SLOT = I2S_MAX_SLOT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2s_sck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  input  logic              sample_ready,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(MAX_SLOT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SLOT - 1);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(MAX_SLOT - 2);

  logic              ws_s, sd_s, bit_stb;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_in, word, left_hold;
  logic              ws_prev_q, ws_prev_d;
  logic              take, latch_left, emit_pair, frame_hit;
  int                shamt;

  i2s_adc_receiver_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .sck     (i2s_sck),
    .ws      (i2s_ws),
    .sd      (i2s_sd),
    .ws_s    (ws_s),
    .sd_s    (sd_s),
    .bit_stb (bit_stb)
  );

  // Bits past DATA_W are dropped; short slots are left-justified by shamt.
  assign take     = int'(cnt_q) < DATA_W;
  assign shreg_in = take ? {shreg_q[DATA_W-2:0], sd_s} : shreg_q;
  assign shamt    = take ? (DATA_W - 1 - int'(cnt_q)) : 0;
  assign word     = shreg_in << shamt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    ws_prev_d  = ws_prev_q;
    latch_left = 1'b0;
    emit_pair  = 1'b0;
    frame_hit  = 1'b0;
    if (bit_stb) begin
      ws_prev_d = ws_s;
      if (ws_s != ws_prev_q) begin
        // This edge carries the LSB of the ws_prev word; the next one is the new MSB.
        cnt_d   = '0;
        shreg_d = '0;
        case (state_q)
          ST_UNSYNC: if (ws_s == CH_LEFT) state_d = ST_LEFT;
          ST_LEFT: begin
            latch_left = 1'b1;
            state_d    = ST_RIGHT;
          end
          ST_RIGHT: begin
            emit_pair = 1'b1;
            state_d   = ST_LEFT;
          end
          default: state_d = ST_UNSYNC;
        endcase
      end else begin
        shreg_d = shreg_in;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (state_q != ST_UNSYNC && cnt_q == CNT_HIT) begin
          frame_hit = 1'b1;
          state_d   = ST_UNSYNC;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_UNSYNC;
    else       state_q <= state_d;
  end

  // Handshake: a pair transfers on any clk where sample_valid && sample_ready;
  // outputs hold while valid && !ready, and a pair finishing then is dropped (overrun).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      ws_prev_q    <= 1'b0;
      left_hold    <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      ws_prev_q <= ws_prev_d;
      if (latch_left) left_hold <= word;
      if (frame_hit) frame_err <= 1'b1;
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      if (emit_pair) begin
        if (sample_valid && !sample_ready) begin
          overrun <= 1'b1;
        end else begin
          sample_left  <= left_hold;
          sample_right <= word;
          sample_valid <= 1'b1;
        end
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: BCLK = clk/4, transmitter changes ws/sd on BCLK fall.
module tb_i2s_adc_receiver;

  localparam logic [1:0] S_UNSYNC = 2'd0;
  localparam logic [1:0] S_LEFT   = 2'd1;

  logic        clk;
  logic        reset;
  logic        i2s_sck, i2s_ws, i2s_sd;
  logic        sample_ready;
  logic [31:0] sample_left, sample_right;
  logic        sample_valid, overrun, frame_err;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  i2s_adc_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_sck      (i2s_sck),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic drive_bit(input logic ws, input logic sd);
    @(negedge clk);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (2) @(negedge clk);
    i2s_sck = 1'b1;
    @(negedge clk);
  endtask

  // Philips framing: ws flips on the slot's last (LSB) edge.
  task automatic send_slot(input logic ch, input logic [63:0] word, input int n);
    for (int b = 0; b < n; b++) drive_bit((b == n - 1) ? ~ch : ch, word[n-1-b]);
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // scoreboard: every accepted pair must match the head of exp_q
  always begin
    logic [63:0] e;
    @(negedge clk);
    #1;
    if (!reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        check("pair_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("pair_left", sample_left, e[63:32]);
        check("pair_right", sample_right, e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    i2s_sck = 1'b0;
    i2s_ws = 1'b0;
    i2s_sd = 1'b0;
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", sample_valid, 0);
    check("rst_left", sample_left, 0);
    check("rst_right", sample_right, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    settle();
    check("rst_state", state_dbg, S_UNSYNC);

    // basic pair with latency measured from the final right->left sck rise
    send_slot(1'b1, 64'h0, 32);
    settle();
    check("sync_state", state_dbg, S_LEFT);
    check("sync_no_valid", sample_valid, 0);
    exp_q.push_back({32'hA5A5_0001, 32'h8000_00FF});
    send_slot(1'b0, 64'hA5A5_0001, 32);
    r = 32'h8000_00FF;
    for (int b = 0; b < 31; b++) drive_bit(1'b1, r[31-b]);
    drive_bit(1'b0, r[0]);
    repeat (2) @(negedge clk);
    check("lat_early", sample_valid, 0);
    @(negedge clk);
    check("lat_valid", sample_valid, 1);
    check("basic_left", sample_left, 32'hA5A5_0001);
    check("basic_right", sample_right, 32'h8000_00FF);
    @(negedge clk);
    check("valid_pulse_end", sample_valid, 0);

    // sync discard: start mid right slot
    pulse_reset();
    send_slot(1'b1, 64'h3FF, 10);
    settle();
    check("mid_sync_state", state_dbg, S_LEFT);
    send_slot(1'b0, 64'h0F0F_1234, 32);
    settle();
    check("half_frame_no_valid", sample_valid, 0);
    exp_q.push_back({32'h0F0F_1234, 32'h5555_AAAA});
    send_slot(1'b1, 64'h5555_AAAA, 32);
    settle();
    check("mid_sync_drained", 64'(exp_q.size()), 0);

    // short 24-bit slots
    exp_q.push_back({32'h1234_5600, 32'hABCD_EF00});
    send_frame(64'h12_3456, 64'hAB_CDEF, 24);
    settle();
    check("short_drained", 64'(exp_q.size()), 0);

    // long 40-bit slots
    exp_q.push_back({32'hDEAD_BEEF, 32'h0123_4567});
    send_frame(64'hDE_ADBE_EF5A, 64'h01_2345_67FF, 40);
    settle();
    check("long_drained", 64'(exp_q.size()), 0);

    // backpressure across two frames
    @(negedge clk);
    sample_ready = 1'b0;
    exp_q.push_back({32'hCAFE_0001, 32'hBEEF_0002});
    send_frame(64'hCAFE_0001, 64'hBEEF_0002, 32);
    settle();
    check("bp_valid", sample_valid, 1);
    check("bp_overrun_0", overrun, 0);
    send_frame(64'h0BAD_0BAD, 64'h0F00_F00D, 32);
    settle();
    check("bp_overrun_1", overrun, 1);
    check("bp_hold_valid", sample_valid, 1);
    check("bp_hold_left", sample_left, 32'hCAFE_0001);
    check("bp_hold_right", sample_right, 32'hBEEF_0002);
    check("bp_frame_err", frame_err, 0);
    sample_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", sample_valid, 0);
    check("bp_drained", 64'(exp_q.size()), 0);

    // reset in the middle of a left slot
    for (int b = 0; b < 10; b++) drive_bit(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_valid", sample_valid, 0);
    check("mrst_left", sample_left, 0);
    check("mrst_right", sample_right, 0);
    check("mrst_overrun", overrun, 0);
    check("mrst_state", state_dbg, S_UNSYNC);
    reset = 1'b0;
    settle();

    // frame error: ws held low for 70 edges while in sync
    send_slot(1'b1, 64'h0, 32);
    settle();
    check("fe_sync_state", state_dbg, S_LEFT);
    for (int b = 0; b < 62; b++) drive_bit(1'b0, b[0]);
    settle();
    check("fe_early", frame_err, 0);
    for (int b = 62; b < 70; b++) drive_bit(1'b0, b[0]);
    settle();
    check("fe_set", frame_err, 1);
    check("fe_state", state_dbg, S_UNSYNC);
    check("fe_no_valid", sample_valid, 0);
    send_slot(1'b1, 64'h0, 32);
    exp_q.push_back({32'h7654_3210, 32'hFEDC_BA98});
    send_frame(64'h7654_3210, 64'hFEDC_BA98, 32);
    settle();
    check("fe_recover_drained", 64'(exp_q.size()), 0);
    check("fe_sticky", frame_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
